// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and IF/ID pipeline register.
// Optional DELAY_SLOT_EN keeps the fetched delay-slot instruction on a taken branch.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        d_is_jump,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] pc_o,
  input  logic [31:0] im_instr,
  input  logic        im_adel,
  output logic [31:0] d_instr,
  output logic [31:0] d_pc,
  output logic [4:0]  d_exccode,
  output logic        d_bd,
  output logic        d_valid
);

  localparam logic [4:0] EXC_ADEL = 5'd4;

  logic [31:0] r_pc;
  logic [31:0] r_d_instr;
  logic [31:0] r_d_pc;
  logic [4:0]  r_d_exccode;
  logic        r_d_valid;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_fetch_instr;
  logic [4:0]  w_fetch_exccode;

  // Wraps modulo 2^32; an out-of-range result is reported by im_adel on fetch.
  assign w_pc_plus4      = r_pc + 32'd4;
  assign w_fetch_instr   = im_adel ? 32'd0 : im_instr;
  assign w_fetch_exccode = im_adel ? EXC_ADEL : 5'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_d_instr   <= 32'd0;
      r_d_pc      <= 32'd0;
      r_d_exccode <= 5'd0;
      r_d_valid   <= 1'b0;
    end else if (exc_req) begin
      r_pc        <= EXC_VECTOR;
      r_d_instr   <= 32'd0;
      r_d_pc      <= EXC_VECTOR;
      r_d_exccode <= 5'd0;
      r_d_valid   <= 1'b0;
    end else if (eret_req) begin
      r_pc        <= epc;
      r_d_instr   <= 32'd0;
      r_d_pc      <= epc;
      r_d_exccode <= 5'd0;
      r_d_valid   <= 1'b0;
    end else if (!stall) begin
      r_pc   <= branch_taken ? branch_target : w_pc_plus4;
      r_d_pc <= r_pc;
`ifdef DELAY_SLOT_EN
      r_d_instr   <= w_fetch_instr;
      r_d_exccode <= w_fetch_exccode;
      r_d_valid   <= 1'b1;
`else
      // Without delay slots the fall-through fetch is squashed into a bubble.
      r_d_instr   <= branch_taken ? 32'd0 : w_fetch_instr;
      r_d_exccode <= branch_taken ? 5'd0 : w_fetch_exccode;
      r_d_valid   <= !branch_taken;
`endif
    end
  end

`ifdef DELAY_SLOT_EN
  logic r_d_bd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_d_bd <= 1'b0;
    end else if (exc_req || eret_req) begin
      r_d_bd <= 1'b0;
    end else if (!stall) begin
      r_d_bd <= d_is_jump;
    end
  end

  assign d_bd = r_d_bd;
`else
  logic w_unused_is_jump;

  assign w_unused_is_jump = d_is_jump;
  assign d_bd             = 1'b0;
`endif

  assign pc_o      = r_pc;
  assign d_instr   = r_d_instr;
  assign d_pc      = r_d_pc;
  assign d_exccode = r_d_exccode;
  assign d_valid   = r_d_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes hand-computed post-edge state,
// a monitor pops and compares one entry after every rising edge.
module tb_fetch_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] dpc;
    logic [4:0]  exc;
    logic        bd;
    logic        valid;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        d_is_jump;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] pc_o;
  logic [31:0] im_instr;
  logic        im_adel;
  logic        im_override;
  logic [31:0] d_instr;
  logic [31:0] d_pc;
  logic [4:0]  d_exccode;
  logic        d_bd;
  logic        d_valid;

  int   total = 0;
  int   bad = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  // Instruction memory: word at address A reads 0x2400_<A[15:0]>; override forces all-ones.
  assign im_instr = im_override ? 32'hFFFF_FFFF : {16'h2400, pc_o[15:0]};

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .d_is_jump(d_is_jump), .exc_req(exc_req),
    .eret_req(eret_req), .epc(epc), .pc_o(pc_o), .im_instr(im_instr),
    .im_adel(im_adel), .d_instr(d_instr), .d_pc(d_pc), .d_exccode(d_exccode),
    .d_bd(d_bd), .d_valid(d_valid)
  );

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] instr,
                              input logic [31:0] dpc, input logic [4:0] exc,
                              input logic bd, input logic valid);
    exp_t e;
    e.pc = pc; e.instr = instr; e.dpc = dpc; e.exc = exc; e.bd = bd; e.valid = valid;
    return e;
  endfunction

  function automatic logic [31:0] iw(input logic [31:0] a);
    return {16'h2400, a[15:0]};
  endfunction

  task automatic check(input string name, input exp_t e);
    exp_t act;
    act = mk(pc_o, d_instr, d_pc, d_exccode, d_bd, d_valid);
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s: got pc=%h instr=%h dpc=%h exc=%0d bd=%b v=%b, need pc=%h instr=%h dpc=%h exc=%0d bd=%b v=%b",
               name, act.pc, act.instr, act.dpc, act.exc, act.bd, act.valid,
               e.pc, e.instr, e.dpc, e.exc, e.bd, e.valid);
    end else begin
      $display("ok %s: pc=%h instr=%h dpc=%h exc=%0d bd=%b v=%b",
               name, act.pc, act.instr, act.dpc, act.exc, act.bd, act.valid);
    end
  endtask

  // Monitor: one comparison after each rising edge for which an expectation is queued.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) check("edge", sb_q.pop_front());
    end
  end

  // Push the state expected after the coming edge, then move to the next falling edge.
  task automatic x(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] dpc,
                   input logic [4:0] exc, input logic bd, input logic valid);
    sb_q.push_back(mk(pc, instr, dpc, exc, bd, valid));
    @(negedge clk);
  endtask

  logic [31:0] h_instr;
  logic        h_valid;

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
    d_is_jump = 1'b0; exc_req = 1'b0; eret_req = 1'b0; epc = 32'd0;
    im_adel = 1'b0; im_override = 1'b0;
    #2;
    check("reset_state", mk(32'h3000, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0));
    @(negedge clk);
    reset = 1'b0;
    x(32'h3004, iw(32'h3000), 32'h3000, 5'd0, 1'b0, 1'b1);
    x(32'h3008, iw(32'h3004), 32'h3004, 5'd0, 1'b0, 1'b1);

    // Taken branch at 3008 whose fetch is a delay slot.
    branch_taken = 1'b1; branch_target = 32'h3400; d_is_jump = 1'b1;
`ifdef DELAY_SLOT_EN
    x(32'h3400, iw(32'h3008), 32'h3008, 5'd0, 1'b1, 1'b1);
`else
    x(32'h3400, 32'd0, 32'h3008, 5'd0, 1'b0, 1'b0);
`endif
    branch_taken = 1'b0; d_is_jump = 1'b0;
    x(32'h3404, iw(32'h3400), 32'h3400, 5'd0, 1'b0, 1'b1);

    // Branch back to 300C with no delay-slot marker.
    branch_taken = 1'b1; branch_target = 32'h300C;
`ifdef DELAY_SLOT_EN
    h_instr = iw(32'h3404); h_valid = 1'b1;
`else
    h_instr = 32'd0; h_valid = 1'b0;
`endif
    x(32'h300C, h_instr, 32'h3404, 5'd0, 1'b0, h_valid);

    // Three stalled cycles; a branch pulse in the middle must be ignored.
    branch_taken = 1'b0; stall = 1'b1; branch_target = 32'h3400;
    for (int i = 0; i < 3; i++) begin
      branch_taken = (i == 1);
      x(32'h300C, h_instr, 32'h3404, 5'd0, 1'b0, h_valid);
    end
    stall = 1'b0; branch_taken = 1'b0;
    x(32'h3010, iw(32'h300C), 32'h300C, 5'd0, 1'b0, 1'b1);

    // Address-error fetch with an all-ones word on the bus.
    im_adel = 1'b1; im_override = 1'b1;
    x(32'h3014, 32'd0, 32'h3010, 5'd4, 1'b0, 1'b1);
    im_adel = 1'b0; im_override = 1'b0;
    x(32'h3018, iw(32'h3014), 32'h3014, 5'd0, 1'b0, 1'b1);
    x(32'h301C, iw(32'h3018), 32'h3018, 5'd0, 1'b0, 1'b1);
    x(32'h3020, iw(32'h301C), 32'h301C, 5'd0, 1'b0, 1'b1);

    // Exception overrides stall; eret overrides stall too.
    exc_req = 1'b1; stall = 1'b1;
    x(32'h4180, 32'd0, 32'h4180, 5'd0, 1'b0, 1'b0);
    exc_req = 1'b0; eret_req = 1'b1; epc = 32'h3020;
    x(32'h3020, 32'd0, 32'h3020, 5'd0, 1'b0, 1'b0);
    eret_req = 1'b0; stall = 1'b0;
    x(32'h3024, iw(32'h3020), 32'h3020, 5'd0, 1'b0, 1'b1);

    // Exception beats a simultaneous eret.
    exc_req = 1'b1; eret_req = 1'b1; epc = 32'h3000;
    x(32'h4180, 32'd0, 32'h4180, 5'd0, 1'b0, 1'b0);
    exc_req = 1'b0; epc = 32'h3038;
    x(32'h3038, 32'd0, 32'h3038, 5'd0, 1'b0, 1'b0);
    eret_req = 1'b0;
    x(32'h303C, iw(32'h3038), 32'h3038, 5'd0, 1'b0, 1'b1);
    x(32'h3040, iw(32'h303C), 32'h303C, 5'd0, 1'b0, 1'b1);
    x(32'h3044, iw(32'h3040), 32'h3040, 5'd0, 1'b0, 1'b1);

    // Mid-cycle reset with a pending redirect: clears immediately and forgets it.
    branch_taken = 1'b1; branch_target = 32'h3400;
    #2 reset = 1'b1;
    #1 check("async_reset", mk(32'h3000, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0));
    @(negedge clk);
    reset = 1'b0; branch_taken = 1'b0;
    x(32'h3004, iw(32'h3000), 32'h3000, 5'd0, 1'b0, 1'b1);

    // Branch to the top word, then PC+4 wraps to zero on an address-error fetch.
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC; d_is_jump = 1'b1;
`ifdef DELAY_SLOT_EN
    x(32'hFFFF_FFFC, iw(32'h3004), 32'h3004, 5'd0, 1'b1, 1'b1);
`else
    x(32'hFFFF_FFFC, 32'd0, 32'h3004, 5'd0, 1'b0, 1'b0);
`endif
    branch_taken = 1'b0; d_is_jump = 1'b0; im_adel = 1'b1;
    x(32'h0000_0000, 32'd0, 32'hFFFF_FFFC, 5'd4, 1'b0, 1'b1);
    im_adel = 1'b0;
    x(32'h0000_0004, 32'h2400_0000, 32'h0000_0000, 5'd0, 1'b0, 1'b1);

    for (int t = 0; t < 20 && sb_q.size() > 0; t++) @(negedge clk);
    if (sb_q.size() > 0) begin
      total++; bad++;
      $display("FAIL drain: got %0d entries left, need 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
